sysid_rom_ctrl: RTL and testbench
=================================

SYSID_ROM_CTRL -- requirements
Module: sysid_rom_ctrl

Interface
REQ-001 SHALL have parameter ROM_WIDTH, default 32, ROM data width in bits; it must be a multiple of 8.
REQ-002 SHALL have parameter ROM_ADDR_BITS, default 6, ROM address width; the ROM depth is 2**ROM_ADDR_BITS words.
REQ-003 SHALL have parameter AUTO_SCAN, default 1: 1 = start a scan on reset release; 0 = wait for scan_start.
REQ-004 clk  input  1  single clock; every register is clocked on the rising edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 host_rd_req  input  1  host read request; a read is issued on every cycle it is high.
REQ-007 host_rd_addr  input  ROM_ADDR_BITS  host read address.
REQ-008 host_rd_valid  output  1  host read data valid strobe.
REQ-009 host_rd_data  output  ROM_WIDTH  host read data.
REQ-010 scan_start  input  1  single-cycle pulse that requests a checksum scan.
REQ-011 scan_busy  output  1  high while a scan is in progress.
REQ-012 scan_done  output  1  sticky; set when a scan completes.
REQ-013 checksum  output  8  byte sum (mod 256) of the last completed scan.
REQ-014 checksum_ok  output  1  high when checksum == 8'h00 and scan_done is high.
REQ-015 rom_addr  output  ROM_ADDR_BITS  address to the ROM; combinational mux of the granted requester.
REQ-016 rom_data  input  ROM_WIDTH  ROM read data; valid one cycle after rom_addr is presented.

Function
REQ-017 Arbitration: fixed priority, host over scanner; the host is never stalled, so there is no host ready signal.
REQ-018 Host path: host_rd_req=1 in cycle T -> rom_addr=host_rd_addr in T; host_rd_valid=1 in T+1 with host_rd_data=rom_data.
- Back-to-back host reads are supported at 1 word/cycle.
REQ-019 FSM states: IDLE, SCAN, DRAIN.
- IDLE -> SCAN on scan_start, or on the first cycle after reset release when AUTO_SCAN=1.
- SCAN -> DRAIN when the scanner issues the last address, 2**ROM_ADDR_BITS-1.
- DRAIN -> IDLE in the cycle that last word's data is accumulated.
REQ-020 On IDLE->SCAN: scan address counter=0, accumulator=0, scan_done cleared.
REQ-021 In SCAN, the scanner issues its address only in cycles with host_rd_req=0, and advances the counter only when it issues.
- Issued scanner reads are tracked by a 1-bit pending flag.
REQ-022 When a scanner read is pending, all ROM_WIDTH/8 bytes of rom_data are added to the 8-bit accumulator with wrap.
REQ-023 On DRAIN->IDLE: checksum=accumulator, scan_done=1.
- The counter wraps via a separate terminal flag, not by overflow, so the last address is issued exactly once.
REQ-024 scan_busy=1 in SCAN and DRAIN.
REQ-025 scan_start received while scan_busy=1 is ignored; it is neither queued nor restarts the scan.
REQ-026 Continuous host_rd_req stalls the scan indefinitely; the scan result is unaffected by host traffic.
REQ-027 Host reads during a scan return correct data and never contribute to the accumulator.

Reset
REQ-028 Asserting resetn low at any time, including mid-scan, SHALL immediately clear all state; the partial checksum is discarded.
REQ-029 Reset values: state=IDLE, host_rd_valid=0, host_rd_data=0, scan_busy=0, scan_done=0, checksum=0, checksum_ok=0.
- rom_addr=0 while host_rd_req=0.
REQ-030 Releasing resetn with AUTO_SCAN=1 SHALL start a scan on the first clock edge after release.

Configuration
REQ-031 Macro SYSID_ROM_CTRL_CHECKSUM_EN: when defined, the scanner, FSM and accumulator are compiled in as specified above.
REQ-032 Without SYSID_ROM_CTRL_CHECKSUM_EN:
- no scanner logic;
- scan_start is ignored;
- scan_busy=0 and checksum=0;
- scan_done=1 and checksum_ok=1 from the first cycle after reset release;
- the host path is unchanged.

Structure
REQ-033 The FSM state encoding (IDLE/SCAN/DRAIN) and the checksum byte width constant (8) SHALL live in a shared package, sysid_rom_pkg.
REQ-034 A single sub-module, sysid_rom_byte_sum, SHALL implement the combinational ROM_WIDTH-to-8-bit byte sum.
- sysid_rom_ctrl shall instantiate it.

Verification
REQ-035 Reset release, AUTO_SCAN=1, no host traffic, 64 words whose bytes sum to 0 -> scan_busy=1 for exactly 65 cycles, then scan_done=1, checksum=8'h00, checksum_ok=1.
REQ-036 Same ROM with word 5 incremented by 1 -> checksum=8'h01, checksum_ok=0.
REQ-037 host_rd_req held high for 10 cycles starting mid-scan, addresses 0..9:
- host_rd_valid for 10 consecutive cycles with the matching data;
- the scan completes 10 cycles later than in REQ-035 with an identical checksum.
REQ-038 resetn pulsed low at scan address 30 -> all outputs return to reset values; a new full scan follows; the checksum equals the REQ-035 value.
REQ-039 scan_start pulsed while scan_busy=1 -> no restart, and total scan length is unchanged.
- scan_start pulsed after completion -> scan_done drops in the next cycle and the scan reruns.
REQ-040 Build without SYSID_ROM_CTRL_CHECKSUM_EN -> scan_done=1 and checksum_ok=1 one cycle after reset release; host reads still have 1-cycle latency.

Source files
------------

// File: rtl/sysid_rom_pkg.sv
// Purpose    : shared types and constants for the system-ID ROM controller.
// Latency    : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   scan_state_t - checksum scanner FSM encoding (IDLE / SCAN / DRAIN)
//   CSUM_W       - width of the byte-sum checksum (8 bits, sum mod 256)
package sysid_rom_pkg;

    // Checksum is a plain byte sum, so it is always one byte wide.
    localparam int CSUM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

endpackage : sysid_rom_pkg

// File: rtl/sysid_rom_byte_sum.sv
// Purpose    : adds all bytes of one ROM word together, mod 256.
// Latency    : combinational, zero cycles.
// Backpressure: none; pure function of its input.
//
// Parameters:
//   WIDTH - input word width in bits, must be a multiple of 8
// Ports:
//   data  in  [WIDTH-1:0]  ROM word to reduce
//   sum   out [CSUM_W-1:0] byte sum of data, wrapping at 8 bits
module sysid_rom_byte_sum
    import sysid_rom_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]  data,
    input  logic              unused_tie,
    output logic [CSUM_W-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < WIDTH / CSUM_W; i++) begin
            sum = sum + data[i*CSUM_W +: CSUM_W];
        end
    end

endmodule : sysid_rom_byte_sum

// File: rtl/sysid_rom_ctrl.sv
// Purpose    : arbitrates a single-port system-ID ROM between a host read port and
//              a background checksum scanner (fixed priority, host wins).
// Latency    : host read data valid one cycle after the request; a full scan takes
//              2**ROM_ADDR_BITS + 1 busy cycles plus one cycle per stalling host read.
// Backpressure: none on the host side (never stalled); the scanner simply waits in
//              any cycle the host owns the ROM.
//
// Build option: define SYSID_ROM_CTRL_CHECKSUM_EN to compile in the scanner, FSM and
// accumulator. Without it only the host path exists and the status outputs report a
// permanently "done and good" checksum one cycle after reset release.
//
// Parameters:
//   ROM_WIDTH     - ROM data width (multiple of 8)
//   ROM_ADDR_BITS - ROM address width, depth = 2**ROM_ADDR_BITS words
//   AUTO_SCAN     - 1: scan automatically on reset release, 0: wait for scan_start
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   host_rd_req/addr     host read request (one read per high cycle) and address
//   host_rd_valid/data   host read response, one cycle after the request
//   scan_start           single-cycle pulse requesting a checksum scan
//   scan_busy            high while the scanner FSM is in SCAN or DRAIN
//   scan_done            sticky completion flag, cleared when a new scan starts
//   checksum             byte sum of the last completed scan
//   checksum_ok          checksum == 0 and scan_done
//   rom_addr / rom_data  ROM port; data returns one cycle after the address
module sysid_rom_ctrl
    import sysid_rom_pkg::*;
#(
    parameter int ROM_WIDTH     = 32,
    parameter int ROM_ADDR_BITS = 6,
    parameter int AUTO_SCAN     = 1
) (
    input  logic                     clk,
    input  logic                     resetn,

    input  logic                     host_rd_req,
    input  logic [ROM_ADDR_BITS-1:0] host_rd_addr,
    output logic                     host_rd_valid,
    output logic [ROM_WIDTH-1:0]     host_rd_data,

    input  logic                     scan_start,
    output logic                     scan_busy,
    output logic                     scan_done,
    output logic [CSUM_W-1:0]        checksum,
    output logic                     checksum_ok,

    output logic [ROM_ADDR_BITS-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]     rom_data
);

    // ------------------------------------------------------------------
    // Host path: identical in both builds. The ROM returns data one cycle
    // after the address, so the response is the registered request flag
    // gating the live ROM output; no data register is needed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            host_rd_valid <= 1'b0;
        end else begin
            host_rd_valid <= host_rd_req;
        end
    end

    assign host_rd_data = host_rd_valid ? rom_data : '0;

`ifdef SYSID_ROM_CTRL_CHECKSUM_EN

    localparam logic [ROM_ADDR_BITS-1:0] LAST_ADDR    = '1;
    localparam logic [ROM_ADDR_BITS-1:0] PENULT_ADDR  = LAST_ADDR - 1'b1;

    scan_state_t              state;
    logic [ROM_ADDR_BITS-1:0] scan_cnt;
    logic                     scan_last;   // scan_cnt currently holds LAST_ADDR
    logic                     scan_pend;   // scanner read issued last cycle
    logic                     auto_pend;   // one-shot start after reset release
    logic [CSUM_W-1:0]        acc;
    logic [CSUM_W-1:0]        word_sum;
    logic [CSUM_W-1:0]        acc_next;
    logic                     scan_issue;

    // The scanner only gets the ROM in cycles the host leaves idle.
    assign scan_issue = (state == ST_SCAN) && !host_rd_req;

    always_comb begin
        rom_addr = '0;
        if (host_rd_req) begin
            rom_addr = host_rd_addr;
        end else if (scan_issue) begin
            rom_addr = scan_cnt;
        end
    end

    sysid_rom_byte_sum #(
        .WIDTH      (ROM_WIDTH)
    ) u_byte_sum (
        .data       (rom_data),
        .unused_tie (1'b0),
        .sum        (word_sum)
    );

    assign acc_next = acc + word_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            scan_cnt    <= '0;
            scan_last   <= 1'b0;
            scan_pend   <= 1'b0;
            auto_pend   <= (AUTO_SCAN != 0);
            acc         <= '0;
            scan_busy   <= 1'b0;
            scan_done   <= 1'b0;
            checksum    <= '0;
            checksum_ok <= 1'b0;
        end else begin
            // Only ever consumed on the first edge out of reset.
            auto_pend <= 1'b0;
            // Data for a scanner read shows up the cycle after it is issued;
            // host reads never set this, so they never reach the accumulator.
            scan_pend <= scan_issue;

            case (state)
                ST_IDLE: begin
                    if (scan_start || auto_pend) begin
                        state       <= ST_SCAN;
                        scan_cnt    <= '0;
                        scan_last   <= (ROM_ADDR_BITS == 0);
                        acc         <= '0;
                        scan_busy   <= 1'b1;
                        scan_done   <= 1'b0;
                        checksum_ok <= 1'b0;
                    end
                end

                ST_SCAN: begin
                    if (scan_pend) begin
                        acc <= acc_next;
                    end
                    if (scan_issue) begin
                        // The terminal flag, not counter overflow, ends the
                        // walk so the last address is issued exactly once.
                        if (scan_last) begin
                            state <= ST_DRAIN;
                        end else begin
                            scan_cnt  <= scan_cnt + 1'b1;
                            scan_last <= (scan_cnt == PENULT_ADDR);
                        end
                    end
                end

                ST_DRAIN: begin
                    // The last address was issued the previous cycle, so its
                    // data is on rom_data now.
                    if (scan_pend) begin
                        acc         <= acc_next;
                        checksum    <= acc_next;
                        checksum_ok <= (acc_next == '0);
                        scan_done   <= 1'b1;
                        scan_busy   <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

`else

    // No scanner: the ROM belongs to the host alone.
    logic ready_q;

    assign rom_addr = host_rd_req ? host_rd_addr : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign scan_busy   = 1'b0;
    assign checksum    = '0;
    assign scan_done   = ready_q;
    assign checksum_ok = ready_q;

    logic unused_scan_cfg;
    assign unused_scan_cfg = &{1'b0, scan_start, (AUTO_SCAN != 0)};

`endif

endmodule : sysid_rom_ctrl

// File: tb/tb_sysid_rom_ctrl.sv
// Purpose    : directed, self-checking bench for sysid_rom_ctrl (default parameters).
// Latency    : n/a.
// Backpressure: n/a.
//
// The ROM is modelled as a 64x32 array with one cycle read latency. Every word is
// {i, -i, A5, 5B}, so each word's bytes sum to 0 and the whole ROM checksums to 0.
// Checks follow whichever build the RTL was compiled with (SYSID_ROM_CTRL_CHECKSUM_EN).
module tb_sysid_rom_ctrl;

    logic        clk;
    logic        resetn;
    logic        host_rd_req;
    logic [5:0]  host_rd_addr;
    logic        host_rd_valid;
    logic [31:0] host_rd_data;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic [7:0]  checksum;
    logic        checksum_ok;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;

    logic [31:0] rom [64];

    int n_vec = 0;
    int n_err = 0;

    sysid_rom_ctrl #(
        .ROM_WIDTH     (32),
        .ROM_ADDR_BITS (6),
        .AUTO_SCAN     (1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .host_rd_req   (host_rd_req),
        .host_rd_addr  (host_rd_addr),
        .host_rd_valid (host_rd_valid),
        .host_rd_data  (host_rd_data),
        .scan_start    (scan_start),
        .scan_busy     (scan_busy),
        .scan_done     (scan_done),
        .checksum      (checksum),
        .checksum_ok   (checksum_ok),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

`ifdef SYSID_ROM_CTRL_CHECKSUM_EN
    // Runs from the first negedge after a scan start until scan_busy drops.
    // Optional host burst over cycles [hf, hf+hn) reading addresses 0.., and an
    // optional scan_start pulse in cycle pulse_at.
    task automatic run_scan(input int hf, input int hn, input int pulse_at,
                            output int busy_n);
        busy_n = 0;
        for (int c = 0; c < 400; c++) begin
            if (c > hf && c <= hf + hn) begin
                chk("host_vld", {31'd0, host_rd_valid}, 32'd1);
                chk("host_dat", host_rd_data, rom[c - 1 - hf]);
            end else if (hn > 0 && c == hf + hn + 1) begin
                chk("host_vld_end", {31'd0, host_rd_valid}, 32'd0);
            end
            if (!scan_busy) break;
            busy_n++;
            scan_start   = (c == pulse_at);
            host_rd_req  = (c >= hf && c < hf + hn);
            host_rd_addr = 6'(c - hf);
            if (host_rd_req) begin
                #1;
                chk("host_rom_addr", {26'd0, rom_addr}, {26'd0, host_rd_addr});
            end
            @(negedge clk);
        end
        host_rd_req = 1'b0;
        scan_start  = 1'b0;
        chk("scan_ended", {31'd0, scan_busy}, 32'd0);
    endtask
`endif

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  {31'd0, scan_busy},     32'd0);
        chk({tag, "_done"},  {31'd0, scan_done},     32'd0);
        chk({tag, "_csum"},  {24'd0, checksum},      32'd0);
        chk({tag, "_ok"},    {31'd0, checksum_ok},   32'd0);
        chk({tag, "_vld"},   {31'd0, host_rd_valid}, 32'd0);
        chk({tag, "_dat"},   host_rd_data,           32'd0);
        chk({tag, "_addr"},  {26'd0, rom_addr},      32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_n;
        logic [5:0] addrs [5];
        logic [7:0] b;

        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            rom[i] = {b, 8'(8'd0 - b), 8'hA5, 8'h5B};
        end
        addrs = '{6'd3, 6'd7, 6'd12, 6'd63, 6'd0};

        resetn       = 1'b0;
        host_rd_req  = 1'b0;
        host_rd_addr = '0;
        scan_start   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");

`ifdef SYSID_ROM_CTRL_CHECKSUM_EN
        // Auto scan on reset release, all-zero checksum ROM.
        resetn = 1'b1;
        @(negedge clk);
        run_scan(-1, 0, -1, busy_n);
        chk("auto_busy_len", busy_n, 32'd65);
        chk("auto_done",     {31'd0, scan_done},   32'd1);
        chk("auto_csum",     {24'd0, checksum},    32'h00);
        chk("auto_ok",       {31'd0, checksum_ok}, 32'd1);

        // Word 5 plus one: checksum 01. scan_start after completion drops done.
        rom[5] = rom[5] + 32'd1;
        scan_start = 1'b1;
        @(negedge clk);
        chk("restart_done_drop", {31'd0, scan_done}, 32'd0);
        chk("restart_busy",      {31'd0, scan_busy}, 32'd1);
        run_scan(-1, 0, -1, busy_n);
        chk("w5_busy_len", busy_n, 32'd65);
        chk("w5_csum",     {24'd0, checksum},    32'h01);
        chk("w5_ok",       {31'd0, checksum_ok}, 32'd0);
        rom[5] = rom[5] - 32'd1;

        // Reset while the scanner is on address 30.
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_addr30", {26'd0, rom_addr}, 32'd30);
        chk("mid_old_csum", {24'd0, checksum}, 32'h01);
        resetn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_scan(-1, 0, -1, busy_n);
        chk("rescan_busy_len", busy_n, 32'd65);
        chk("rescan_csum",     {24'd0, checksum},    32'h00);
        chk("rescan_ok",       {31'd0, checksum_ok}, 32'd1);

        // Ten host reads mid-scan stall the scan by ten cycles.
        scan_start = 1'b1;
        @(negedge clk);
        run_scan(20, 10, -1, busy_n);
        chk("host_busy_len", busy_n, 32'd75);
        chk("host_csum",     {24'd0, checksum},    32'h00);
        chk("host_ok",       {31'd0, checksum_ok}, 32'd1);

        // scan_start while busy (mid-scan, then in DRAIN) is ignored.
        scan_start = 1'b1;
        @(negedge clk);
        run_scan(-1, 0, 30, busy_n);
        chk("ign_mid_len", busy_n, 32'd65);
        scan_start = 1'b1;
        @(negedge clk);
        run_scan(-1, 0, 64, busy_n);
        chk("ign_drain_len", busy_n, 32'd65);
        @(negedge clk);
        chk("ign_no_queue", {31'd0, scan_busy}, 32'd0);
        chk("ign_done",     {31'd0, scan_done}, 32'd1);
        chk("ign_csum",     {24'd0, checksum},  32'h00);
`else
        resetn = 1'b1;
        @(negedge clk);
        chk("nocs_done", {31'd0, scan_done},   32'd1);
        chk("nocs_ok",   {31'd0, checksum_ok}, 32'd1);
        chk("nocs_busy", {31'd0, scan_busy},   32'd0);
        chk("nocs_csum", {24'd0, checksum},    32'd0);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        chk("nocs_start_busy", {31'd0, scan_busy}, 32'd0);
        chk("nocs_start_done", {31'd0, scan_done}, 32'd1);
`endif

        // Back-to-back host reads, one-cycle latency.
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                chk("b2b_vld", {31'd0, host_rd_valid}, 32'd1);
                chk("b2b_dat", host_rd_data, rom[addrs[k-1]]);
            end
            if (k < 5) begin
                host_rd_req  = 1'b1;
                host_rd_addr = addrs[k];
                #1;
                chk("b2b_rom_addr", {26'd0, rom_addr}, {26'd0, addrs[k]});
            end else begin
                host_rd_req = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_vld_end", {31'd0, host_rd_valid}, 32'd0);
        chk("b2b_dat_end", host_rd_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sysid_rom_ctrl
